aes_key_sched_ctrl: RTL

Sequencer that turns one 128-bit AES cipher key into the full set of 11 round keys. It accepts the key over a valid/ready handshake and drives the existing combinational `KeyExpansion` block once per clock for rounds 0..9. Results are stored in an internal 11-entry round-key register file. The cipher round controller reads that file through a random-access port once `keys_valid` is asserted.

---
 rtl/aes_key_sched_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer.
// Accepts one cipher key over a valid/ready handshake, runs the single-step
// KeyExpansion datapath once per clock to fill an 11-entry round-key file,
// and exposes that file through a combinational random-access read port.

// One AES-128 key-expansion step: derives round key (round+1) from round key
// (round). Purely combinational; round is the 0-based step index 0..9.
module KeyExpansion (
    input  logic [127:0] key,
    input  logic [3:0]   round,
    output logic [127:0] expanded_key
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // S-box computed as the multiplicative inverse (x^254, which maps 0 to 0)
    // followed by the AES affine transform, instead of a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] inv;
        pw  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [7:0]  rcon;
    logic [31:0] temp_word;
    logic [31:0] n0, n1, n2, n3;

    assign w0       = key[127:96];
    assign w1       = key[95:64];
    assign w2       = key[63:32];
    assign w3       = key[31:0];
    assign rot_word = {w3[23:0], w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_sub
            assign sub_word[gi*8 +: 8] = sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

    // Round constant for the step being produced.
    always_comb begin
        rcon = 8'h00;
        case (round)
            4'd0: rcon = 8'h01;
            4'd1: rcon = 8'h02;
            4'd2: rcon = 8'h04;
            4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;
            4'd5: rcon = 8'h20;
            4'd6: rcon = 8'h40;
            4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;
            4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign temp_word    = sub_word ^ {rcon, 24'h000000};
    assign n0           = w0 ^ temp_word;
    assign n1           = w1 ^ n0;
    assign n2           = w2 ^ n1;
    assign n3           = w3 ^ n2;
    assign expanded_key = {n0, n1, n2, n3};

endmodule

module aes_key_sched_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NR - 1);

    state_t       state_reg;
    logic [3:0]   rnd_reg;
    logic         key_ready_reg;
    logic         busy_reg;
    logic         keys_valid_reg;

    logic         load_en;
    logic         expand_en;
    logic [127:0] step_key;
    logic [127:0] expanded_key;

    // Read view of the key file padded to the full 4-bit address space;
    // entries above NR are tied to zero so out-of-range reads return 0.
    logic [127:0] rk_rd [0:15];

    assign load_en   = key_valid && ((state_reg == IDLE) || (state_reg == READY));
    assign expand_en = (state_reg == EXPAND);
    assign step_key  = rk_rd[rnd_reg];

    KeyExpansion u_key_expansion (
        .key          (step_key),
        .round        (rnd_reg),
        .expanded_key (expanded_key)
    );

    // Control FSM: tracks the expansion step and produces registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            rnd_reg        <= 4'd0;
            key_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            keys_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, READY: begin
                    if (key_valid) begin
                        state_reg      <= EXPAND;
                        rnd_reg        <= 4'd0;
                        key_ready_reg  <= 1'b0;
                        busy_reg       <= 1'b1;
                        keys_valid_reg <= 1'b0;
                    end else begin
                        rnd_reg        <= 4'd0;
                        key_ready_reg  <= 1'b1;
                        busy_reg       <= 1'b0;
                        keys_valid_reg <= (state_reg == READY);
                    end
                end
                EXPAND: begin
                    if (rnd_reg >= LAST_RND) begin
                        state_reg      <= READY;
                        rnd_reg        <= 4'd0;
                        key_ready_reg  <= 1'b1;
                        busy_reg       <= 1'b0;
                        keys_valid_reg <= 1'b1;
                    end else begin
                        rnd_reg        <= rnd_reg + 4'd1;
                        key_ready_reg  <= 1'b0;
                        busy_reg       <= 1'b1;
                        keys_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    rnd_reg        <= 4'd0;
                    key_ready_reg  <= 1'b1;
                    busy_reg       <= 1'b0;
                    keys_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : gen_rk
            if (gi == 0) begin : g_key
                logic [127:0] entry_reg;
                // Entry 0 holds the cipher key captured at the handshake.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        entry_reg <= '0;
                    end else if (load_en) begin
                        entry_reg <= key_in;
                    end
                end
                assign rk_rd[gi] = entry_reg;
            end else if (gi <= NR) begin : g_round
                logic [127:0] entry_reg;
                // Entry gi is written by the expansion step whose counter is gi-1.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        entry_reg <= '0;
                    end else if (expand_en && (rnd_reg == 4'(gi - 1))) begin
                        entry_reg <= expanded_key;
                    end
                end
                assign rk_rd[gi] = entry_reg;
            end else begin : g_zero
                assign rk_rd[gi] = '0;
            end
        end
    endgenerate

    assign rk_out     = rk_rd[rk_addr];
    assign key_ready  = key_ready_reg;
    assign busy       = busy_reg;
    assign keys_valid = keys_valid_reg;

endmodule
